alu_mdu_seq: RTL
================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised, registered successor to the combinational 32-bit ALU.
//  - Single-cycle logic/arith/shift ops: 1-edge latency.
//  - Iterative signed/unsigned multiply and divide, writing a HI/LO pair.
//  - start/busy/done handshake towards the EX stage controller.
// PARAMETERS
//  WIDTH   32  operand/result width; legal values are powers of 2, >= 4
//  SHW     $clog2(WIDTH)  shift-amount width (derived; do not override)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  ALUOp   in   4      operation code, sampled with start
//  A       in   WIDTH  operand A, sampled with start
//  B       in   WIDTH  operand B, sampled with start
//  C       out  WIDTH  result (single-cycle ops: result; mult/div: copy of LO)
//  HI      out  WIDTH  mult: upper product half; div: remainder
//  LO      out  WIDTH  mult: lower product half; div: quotient
//  busy    out  1      iterative op in flight
//  done    out  1      one-cycle pulse: C/HI/LO valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; C, HI, LO, busy, done, counter all 0.
//   An in-flight op is discarded; no result is written.
//  ALUOp encoding (arithmetic wraps mod 2^WIDTH):
//   0 add  1 sub  2 and  3 or
//   4 srl  5 sra  6 sll  7 slt (signed, C = 0/1)
//   8 mult  9 multu  10 div  11 divu
//   12-15 reserved: treated as add
//  Shifts use B[SHW-1:0] only; sra fills with A[WIDTH-1].
//  States: IDLE, CALC, FIX.
//  IDLE, start=1, op<8 or reserved:
//   edge 0 writes C; done=1 for the next cycle; stay IDLE.
//   HI and LO are unchanged.
//  IDLE, start=1, op 8-11:
//   edge 0 latches |A|, |B| (signed ops) or raw values, plus the result signs.
//   -> CALC, cnt=0, busy=1.
//  CALC: one shift-add (mult) or restoring-subtract (div) step per edge.
//   After WIDTH steps (edge WIDTH) -> FIX.
//  FIX, edge WIDTH+1:
//   - Apply sign correction; write HI, LO, C=LO; done=1; busy=0; -> IDLE.
//   - Total latency: done observed after edge WIDTH+1 (33 for WIDTH=32).
//  Signed div:
//   - Quotient truncates toward zero; remainder takes the sign of A.
//   - MIN/-1 gives LO=MIN, HI=0 (no trap).
//  Divide by zero (both div types):
//   - Still takes full latency.
//   - LO = all ones, HI = A (raw operand).
//  start while busy=1: ignored; ALUOp/A/B are not sampled.
//  Back-to-back: start in the cycle done=1 is accepted (state is IDLE).
//  done is never high for two consecutive cycles from one request.
//  busy and done are never high together.
// TESTING (WIDTH=32)
//  1. sra A=0xFFFFFFF8, B=2
//     -> C=0xFFFFFFFE, done=1 after edge 1, busy stays 0.
//  2. mult A=-3, B=5
//     -> after edge 33: HI=0xFFFFFFFF, LO=C=0xFFFFFFF1, one-cycle done.
//  3. div A=-7, B=2
//     -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
//  4. Start a multu, then pulse start with div at edge 5
//     -> ignored; multu result correct; only one done pulse.
//  5. Drop rst_n at edge 10 of a div
//     -> outputs go to 0 immediately; no done.
//     A new add 1+2 after release -> C=3.
//  6. Issue slt (-1 < 1) in the done cycle of a mult
//     -> accepted; C=1 next cycle; HI/LO keep the mult result.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// Registered ALU with iterative multiply/divide unit.
// Single-cycle ops complete on the sampling edge; mult/div run one
// shift-add or restoring-subtract step per edge and finish in FIX.
//
// state | meaning
// IDLE  | ready; start samples ALUOp/A/B
// CALC  | one mult/div step per edge, WIDTH steps total
// FIX   | sign correction, write HI/LO/C, pulse done
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] wk_hi, wk_lo, opd_b, a_raw;
  logic             is_div, neg_q, neg_r, dz;

  logic             is_long, op_signed, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b, alu_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  // Operands of signed mult/div are reduced to magnitudes; signs kept aside
  assign is_long   = (ALUOp[3:2] == 2'b10);
  assign op_signed = ~ALUOp[0];
  assign sa        = op_signed & A[WIDTH-1];
  assign sb        = op_signed & B[WIDTH-1];
  assign mag_a     = sa ? -A : A;
  assign mag_b     = sb ? -B : B;
  assign shamt     = B[SHW-1:0];
  assign busy      = (state_q != IDLE);

  // Single-cycle result; reserved codes fall through to add
  always_comb begin
    alu_res = A + B;
    case (ALUOp)
      4'd1:    alu_res = A - B;
      4'd2:    alu_res = A & B;
      4'd3:    alu_res = A | B;
      4'd4:    alu_res = A >> shamt;
      4'd5:    alu_res = $unsigned($signed(A) >>> shamt);
      4'd6:    alu_res = A << shamt;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = A + B;
    endcase
  end

  // Iteration datapath and final sign correction
  always_comb begin
    add_sum  = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opd_b} : '0);
    rem_sh   = {wk_hi, wk_lo[WIDTH-1]};
    diff     = rem_sh - {1'b0, opd_b};
    prod     = {wk_hi, wk_lo};
    prod_fix = neg_q ? -prod : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? -wk_hi : wk_hi;
        fix_lo = neg_q ? -wk_lo : wk_lo;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && is_long) state_d = CALC;
      CALC:    if (cnt == SHW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration steps and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C      <= '0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      wk_hi  <= '0;
      wk_lo  <= '0;
      opd_b  <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_long) begin
              cnt    <= '0;
              wk_hi  <= '0;
              wk_lo  <= mag_a;
              opd_b  <= mag_b;
              a_raw  <= A;
              is_div <= ALUOp[1];
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
              dz     <= (B == '0);
            end else begin
              C    <= alu_res;
              done <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            wk_hi <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            wk_lo <= {wk_lo[WIDTH-2:0], ~diff[WIDTH]};
          end else begin
            wk_hi <= add_sum[WIDTH:1];
            wk_lo <= {add_sum[0], wk_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          HI   <= fix_hi;
          LO   <= fix_lo;
          C    <= fix_lo;
          done <= 1'b1;
          cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
